// File: rtl/uart_pkg.sv
// uart_pkg: shared trigger levels, capture FSM states and frame helpers for the UART RX path
// Contents: TRIG_LVL_* constants, cap_state_t, trig_level() and char_bits().
package uart_pkg;
  localparam logic [7:0] TRIG_LVL_1  = 8'd1;
  localparam logic [7:0] TRIG_LVL_4  = 8'd4;
  localparam logic [7:0] TRIG_LVL_8  = 8'd8;
  localparam logic [7:0] TRIG_LVL_14 = 8'd14;
  typedef enum logic {IDLE, WRITE} cap_state_t;
  function automatic logic [7:0] trig_level(input logic [1:0] sel);
    return sel == 2'd0 ? TRIG_LVL_1 : sel == 2'd1 ? TRIG_LVL_4 : sel == 2'd2 ? TRIG_LVL_8 : TRIG_LVL_14;
  endfunction
  // Start bit, 5..8 data bits, optional parity and 1 or 2 stop bits.
  function automatic logic [3:0] char_bits(input logic [1:0] wls, input logic pen, input logic stb);
    return 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RX character store with pointers, count and single-entry overwrite mode
// Ports: CLK/RST (async, active-high); push/pop/clear requests; single selects depth 1
// with overwrite-on-full; din is the 11-bit word; full/empty/count/head report status,
// head reads 0 when empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic                  single,
  input  logic [10:0]           din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [10:0]           head
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [10:0] mem [DEPTH];
  logic do_pop, do_push, ovw;
  assign empty   = count == '0;
  assign full    = single ? !empty : count == (DEPTH_LOG2+1)'(DEPTH);
  assign do_pop  = pop & !empty & !clear;
  assign do_push = push & !clear & (!full | do_pop);
  // In single mode a push onto a full entry replaces it in place.
  assign ovw     = push & !clear & full & !do_pop & single;
  assign head    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      count  <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
    else if (ovw) mem[rd_ptr] <= din;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller with capture stage, RX FIFO, status flags and timeout
// Ports: CLK/RST (async, active-high); RXFINISHED/DIN/PE_IN/FE_IN/BI_IN from the receiver;
// FIFOEN/RXCLEAR/TRIG/WLS/PEN/STB configuration; BITTICK bit-time pulse; RD/LSR_RD read
// strobes; DOUT/PE/FE/BI head entry; DR/OE/FIFOERR/TRIG_HIT/TIMEOUT status; COUNT fill level.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RXFINISHED,
  input  logic [7:0]          DIN,
  input  logic                PE_IN,
  input  logic                FE_IN,
  input  logic                BI_IN,
  input  logic                FIFOEN,
  input  logic                RXCLEAR,
  input  logic [1:0]          TRIG,
  input  logic [1:0]          WLS,
  input  logic                PEN,
  input  logic                STB,
  input  logic                BITTICK,
  input  logic                RD,
  input  logic                LSR_RD,
  output logic [7:0]          DOUT,
  output logic                PE,
  output logic                FE,
  output logic                BI,
  output logic                DR,
  output logic                OE,
  output logic                FIFOERR,
  output logic                TRIG_HIT,
  output logic                TIMEOUT,
  output logic [DEPTH_LOG2:0] COUNT
);
  localparam int CW = DEPTH_LOG2 + 1;
  cap_state_t state, state_n;
  logic [10:0] cap, head;
  logic [CW-1:0] err_cnt;
  logic [5:0] tcnt;
  logic fifoen_q, clr, push, pop, full, empty, overrun, wr_eff, rm_eff;
  // A mode change flushes the FIFO exactly like RXCLEAR.
  assign clr = RXCLEAR | (FIFOEN ^ fifoen_q);
  always_comb begin
    state_n = IDLE;
    push = 1'b0;
    if (RXFINISHED) state_n = WRITE;
    if (state == WRITE) push = !clr;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cap      <= '0;
      fifoen_q <= 1'b0;
    end else begin
      state    <= state_n;
      fifoen_q <= FIFOEN;
      if (RXFINISHED) cap <= {BI_IN, FE_IN, PE_IN, DIN};
    end
  end
  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .single(!FIFOEN),
    .din   (cap),
    .full  (full),
    .empty (empty),
    .count (COUNT),
    .head  (head)
  );
  assign pop     = RD & !empty & !clr;
  assign overrun = push & full & !pop;
  // A word enters storage unless it is discarded on a full FIFO; in single mode
  // an overrun also removes the old head, so the error count must follow both.
  assign wr_eff  = push & (!full | pop | !FIFOEN);
  assign rm_eff  = pop | (overrun & !FIFOEN);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
      tcnt    <= '0;
      OE      <= 1'b0;
    end else begin
      err_cnt <= clr ? '0 : err_cnt + CW'(wr_eff & |cap[10:8]) - CW'(rm_eff & |head[10:8]);
      tcnt    <= (clr | push | pop) ? '0 : tcnt + 6'((BITTICK & !empty & tcnt != 6'h3f));
      OE      <= overrun ? 1'b1 : LSR_RD ? 1'b0 : OE;
    end
  end
  assign {BI, FE, PE, DOUT} = head;
  assign DR       = !empty;
  assign FIFOERR  = err_cnt != '0;
  assign TRIG_HIT = FIFOEN ? 8'(COUNT) >= trig_level(TRIG) : DR;
  assign TIMEOUT  = FIFOEN & !empty & (tcnt >= {char_bits(WLS, PEN, STB), 2'b00});
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving an RX FIFO depth of 2**DEPTH_LOG2 entries (16 by default).
REQ-002 The block SHALL have these ports, with CLK and RST listed first:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- RXFINISHED  in  1  one-cycle pulse from the receiver; character complete
- DIN  in  8  received character
- PE_IN, FE_IN, BI_IN  in  1 each  receiver error flags, valid with RXFINISHED
- FIFOEN  in  1  1 = FIFO mode, 0 = single holding register
- RXCLEAR  in  1  synchronous FIFO flush
- TRIG  in  2  trigger select; 00/01/10/11 = 1/4/8/14 entries
- WLS  in  2  word length select
- PEN  in  1  parity enable
- STB  in  1  stop bits select
- BITTICK  in  1  one pulse per bit time
- RD  in  1  one-cycle RBR read strobe
- LSR_RD  in  1  one-cycle LSR read strobe
- DOUT  out  8  head character
- PE, FE, BI  out  1 each  flags of the head entry
- DR  out  1  data ready; FIFO not empty
- OE  out  1  sticky overrun flag
- FIFOERR  out  1  at least one stored entry has an error
- TRIG_HIT  out  1  entry count >= trigger level
- TIMEOUT  out  1  character timeout
- COUNT  out  DEPTH_LOG2+1  current entry count

Function
REQ-003 On RXFINISHED, the block SHALL latch {BI_IN, FE_IN, PE_IN, DIN} into a capture register and write it into the FIFO on the next cycle; RXFINISHED-to-DR latency is 2 cycles.
- The capture FSM SHALL have states IDLE and WRITE.
- IDLE -> WRITE on RXFINISHED.
- WRITE -> IDLE unconditionally.
- An RXFINISHED arriving while in WRITE SHALL be latched and SHALL keep the FSM in WRITE.
REQ-004 The effective depth SHALL be 2**DEPTH_LOG2 when FIFOEN=1 and 1 when FIFOEN=0.
REQ-005 A write to a full FIFO with FIFOEN=1 SHALL discard the new word and set OE.
REQ-006 A write to a full FIFO with FIFOEN=0 SHALL overwrite the single entry and set OE.
REQ-007 RD with DR=1 SHALL pop the head entry; RD with DR=0 SHALL be ignored.
REQ-008 Simultaneous write and pop when full SHALL both take effect, with no overrun and COUNT unchanged.
REQ-009 Read and write pointers SHALL wrap modulo the depth; COUNT SHALL range 0..2**DEPTH_LOG2.
REQ-010 DOUT, PE, FE and BI SHALL show the head entry combinationally, and SHALL be 0 when the FIFO is empty.
REQ-011 OE SHALL clear on LSR_RD; if an overrun occurs in the same cycle as LSR_RD, OE SHALL end at 1.
REQ-012 FIFOERR SHALL be driven by an error-entry counter:
- incremented on a write whose flags are non-zero;
- decremented on a pop of an entry whose flags are non-zero;
- FIFOERR = (counter != 0).
REQ-013 TRIG_HIT SHALL equal (COUNT >= level(TRIG)) when FIFOEN=1, and DR when FIFOEN=0.
REQ-014 Character bit count SHALL be CB = 1 + (5+WLS) + PEN + (1+STB), giving a range of 7..12.
REQ-015 A saturating 6-bit timeout counter SHALL behave as follows:
- clear on any write, pop, or RXCLEAR;
- otherwise increment on BITTICK while COUNT != 0.
REQ-016 TIMEOUT SHALL be 1 when FIFOEN=1, COUNT != 0, and the timeout counter >= 4*CB; it SHALL be 0 otherwise.
REQ-017 RXCLEAR SHALL empty the FIFO, zero the error counter and timeout counter, and abort a pending WRITE; it SHALL NOT clear OE.
REQ-018 Any change of FIFOEN SHALL act as RXCLEAR for one cycle.

Reset
REQ-019 Asserting RST SHALL asynchronously force the following:
- FSM = IDLE;
- pointers, COUNT and all counters = 0;
- DR, OE, FIFOERR, TRIG_HIT and TIMEOUT = 0;
- DOUT = 0x00; PE = FE = BI = 0.
REQ-020 RST asserted mid-WRITE SHALL lose the captured character, and no write SHALL occur after reset release.

Structure
REQ-021 Trigger-level constants (1, 4, 8, 14) and the capture FSM state enum SHALL reside in the shared package uart_pkg.
REQ-022 Storage and pointers SHALL be a sub-module uart_rx_fifo: 11-bit words, parameter DEPTH_LOG2, with ports for push, pop, clear, full, empty, count and head.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Scenario 1: FIFOEN=1; RXFINISHED with DIN=0x41 and flags 0 -> DR=1 two cycles later, DOUT=0x41, COUNT=1; then RD -> DR=0, DOUT=0x00.
- Scenario 2: FIFOEN=1; 17 characters 0x00..0x10 with no RD -> OE=1, COUNT=16, DOUT=0x00; 16 RDs return 0x00..0x0F; LSR_RD -> OE=0.
- Scenario 3: FIFOEN=1, TRIG=10; 7 writes give TRIG_HIT=0, the 8th write gives TRIG_HIT=1; one RD -> TRIG_HIT=0.
- Scenario 4: FIFOEN=1, WLS=11, PEN=1, STB=0 (CB=11); one write, then 43 BITTICKs give TIMEOUT=0 and the 44th gives TIMEOUT=1; RD -> TIMEOUT=0.
- Scenario 5: FIFOEN=0; write 0xAA then 0x55 with no RD -> DOUT=0x55, OE=1, COUNT=1.
- Scenario 6: write 0x00 with BI_IN=FE_IN=1, then write 0x12 -> FIFOERR=1; first RD -> FIFOERR=0, head=0x12; assert RST mid-WRITE -> all outputs 0.
